argmax_scan_counter: RTL

Parametrised two-level (row x column) scan sequencer for the argmax stage. It replaces the fixed single-row wrap counter with a start/done-controlled scan over FEATURE_ROWS x FEATURE_COLS elements, with stall, abort, boundary flags and a linear element index. It sits between the argmax FSM, which issues start/stall/abort, and the output-feature memory read address plus the argmax compare datapath, which consume the counts and flags.

---
 rtl/argmax_scan_counter_if.sv | 35 +++
 rtl/argmax_scan_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/argmax_scan_counter_if.sv
// Control and count bus between the argmax FSM (master) and the scan sequencer (slave).
interface argmax_scan_counter_if #(
  parameter int unsigned FEATURE_ROWS = 6,
  parameter int unsigned FEATURE_COLS = 3
);
  localparam int unsigned ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int unsigned COL_W = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1;
  localparam int unsigned IDX_W = (FEATURE_ROWS * FEATURE_COLS > 1) ?
                                  $clog2(FEATURE_ROWS * FEATURE_COLS) : 1;

  logic             start;
  logic             stall;
  logic             abort;
  logic [ROW_W-1:0] row_count;
  logic [COL_W-1:0] col_count;
  logic [IDX_W-1:0] elem_index;
  logic             valid;
  logic             first_col;
  logic             last_col;
  logic             last_row;
  logic             busy;
  logic             done;

  modport master (
    output start, stall, abort,
    input  row_count, col_count, elem_index, valid,
           first_col, last_col, last_row, busy, done
  );

  modport slave (
    input  start, stall, abort,
    output row_count, col_count, elem_index, valid,
           first_col, last_col, last_row, busy, done
  );
endinterface

// File: rtl/argmax_scan_counter.sv
// Row x column scan sequencer for the argmax stage: start/stall/abort control,
// boundary flags and a linear element index, all driven from flops.
module argmax_scan_counter #(
  parameter int unsigned FEATURE_ROWS = 6,
  parameter int unsigned FEATURE_COLS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  argmax_scan_counter_if.slave  bus
);
  localparam int unsigned ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int unsigned COL_W = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1;
  localparam int unsigned IDX_W = (FEATURE_ROWS * FEATURE_COLS > 1) ?
                                  $clog2(FEATURE_ROWS * FEATURE_COLS) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FEATURE_COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             first_col_q, first_col_d;
  logic             last_col_q, last_col_d;
  logic             last_row_q, last_row_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next state and counts; flags are derived from the next values so they register alongside.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        idx_d = '0;
        if (bus.start && !bus.abort) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
        end else if (!bus.stall) begin
          if (col_q == COL_LAST) begin
            if (row_q == ROW_LAST) begin
              state_d = DONE;
              row_d   = '0;
              col_d   = '0;
              idx_d   = '0;
            end else begin
              row_d = row_q + ROW_W'(1);
              col_d = '0;
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
        idx_d   = '0;
      end
    endcase

    valid_d     = (state_d == SCAN);
    first_col_d = valid_d && (col_d == '0);
    last_col_d  = valid_d && (col_d == COL_LAST);
    last_row_d  = valid_d && (row_d == ROW_LAST);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      first_col_q <= 1'b0;
      last_col_q  <= 1'b0;
      last_row_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      first_col_q <= first_col_d;
      last_col_q  <= last_col_d;
      last_row_q  <= last_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.row_count  = row_q;
  assign bus.col_count  = col_q;
  assign bus.elem_index = idx_q;
  assign bus.valid      = valid_q;
  assign bus.first_col  = first_col_q;
  assign bus.last_col   = last_col_q;
  assign bus.last_row   = last_row_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
